// File: rtl/wb_pkg.sv
// Shared constants for the write-buffer drain scheduler: drain state codes
// presented to the buffer datapath and the fixed AXI write-address fields.
package wb_pkg;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_PULL   = 4'd4;
  localparam logic [3:0] ST_SEND_0 = 4'd5;
  localparam logic [3:0] ST_SEND_1 = 4'd6;
  localparam logic [3:0] ST_SEND_2 = 4'd7;
  localparam logic [3:0] ST_SEND_3 = 4'd8;
  localparam logic [3:0] ST_SEND_4 = 4'd9;
  localparam logic [3:0] ST_SEND_5 = 4'd10;
  localparam logic [3:0] ST_SEND_6 = 4'd11;
  localparam logic [3:0] ST_SEND_7 = 4'd12;
  localparam logic [3:0] ST_WAIT_B = 4'd13;

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/wb_drain_sched.sv
// Write-buffer drain sequencer and AXI arbiter: one INCR burst per buffer entry,
// read refills interleaved with a starvation limit, and a blocking flush.
module wb_drain_sched
  import wb_pkg::*;
#(
  parameter int LENGTH    = 5,
  parameter int BURST_LEN = 8,
  parameter int RD_STARVE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_count,
  output logic [3:0]  crt_pull,
  output logic [3:0]  nxt_pull,
  output logic        awvalid,
  input  logic        awready,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        wvalid,
  input  logic        wready,
  output logic        wlast,
  input  logic        bvalid,
  output logic        bready,
  input  logic        rd_req,
  input  logic        rd_done,
  output logic        rd_grant,
  input  logic        flush_req,
  output logic        dma_sign,
  output logic        flush_done,
  output logic        busy
);

  localparam int SW = $clog2(RD_STARVE + 1);

  // Handshake semantics: a beat transfers on a cycle where both valid and ready
  // are high; valid, once raised, stays high until that transfer happens.

  logic [SW-1:0] starve_cnt;
  logic          idle;
  logic          buf_nonempty;
  logic          buf_full;
  logic          drain_go;
  logic          rd_go;
  logic          flush_hit;

  always_comb begin
    idle         = (crt_pull == ST_IDLE);
    buf_nonempty = (wb_count != 32'd0);
    buf_full     = (wb_count == 32'(LENGTH - 1));
    drain_go     = idle && !rd_grant && !rst && buf_nonempty &&
                   (!rd_req || buf_full || (starve_cnt == SW'(RD_STARVE)) || dma_sign);
    rd_go        = idle && !rd_grant && !rst && !drain_go && rd_req && !dma_sign;
    flush_hit    = idle && dma_sign && !buf_nonempty;
  end

  // nxt_pull is held at IDLE during reset so the buffer never pops on a reset cycle.
  always_comb begin
    nxt_pull = ST_IDLE;
    if (!rst) begin
      case (crt_pull)
        ST_IDLE:   nxt_pull = drain_go ? ST_PULL : ST_IDLE;
        ST_PULL:   nxt_pull = awready ? ST_SEND_0 : ST_PULL;
        ST_SEND_0, ST_SEND_1, ST_SEND_2, ST_SEND_3,
        ST_SEND_4, ST_SEND_5, ST_SEND_6:
                   nxt_pull = wready ? crt_pull + 4'd1 : crt_pull;
        ST_SEND_7: nxt_pull = wready ? ST_WAIT_B : ST_SEND_7;
        ST_WAIT_B: nxt_pull = bvalid ? ST_IDLE : ST_WAIT_B;
        default:   nxt_pull = ST_IDLE;
      endcase
    end
  end

  assign awvalid = (crt_pull == ST_PULL);
  assign wvalid  = (crt_pull >= ST_SEND_0) && (crt_pull <= ST_SEND_7);
  assign wlast   = (crt_pull == ST_SEND_7);
  assign bready  = (crt_pull == ST_WAIT_B);
  assign awlen   = 8'(BURST_LEN - 1);
  assign awsize  = SIZE_4B;
  assign awburst = BURST_INCR;
  assign busy    = !idle || rd_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      crt_pull   <= ST_IDLE;
      rd_grant   <= 1'b0;
      dma_sign   <= 1'b0;
      flush_done <= 1'b0;
      starve_cnt <= '0;
    end else begin
      crt_pull   <= nxt_pull;
      flush_done <= flush_hit;

      if (rd_grant && rd_done)
        rd_grant <= 1'b0;
      else if (rd_go)
        rd_grant <= 1'b1;

      if (flush_hit)
        dma_sign <= 1'b0;
      else if (idle && flush_req)
        dma_sign <= 1'b1;

      // Counts reads that jumped ahead of pending entries; a full count forces a drain.
      if (!buf_nonempty || drain_go)
        starve_cnt <= '0;
      else if (rd_go && (starve_cnt != SW'(RD_STARVE)))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule
